axis_packet_arbiter: RTL and testbench

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

---
 rtl/axis_arb_pkg.sv | 11 +
 rtl/axis_rr_picker.sv | 25 ++
 rtl/axis_packet_arbiter.sv | 81 ++++++++
 tb/tb_axis_packet_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state encoding, default widths and round-robin helper for the packet arbiter
package axis_arb_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int DEF_NUM_IN     = 4;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_DEST_WIDTH = 8;
    localparam int DEF_USER_WIDTH = 8;
    function automatic int rr_next(int g, int n);
        return (g + 1) % n;
    endfunction
endpackage

// File: rtl/axis_rr_picker.sv
// axis_rr_picker: first set bit of valid scanning upward from ptr, wrapping modulo NUM_IN
module axis_rr_picker #(
    parameter int NUM_IN = 4,
    parameter int IW     = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] valid,
    input  logic [IW-1:0]     ptr,
    output logic [IW-1:0]     idx,
    output logic              found
);
    logic [IW-1:0] p;
    // scan from the farthest offset down so the nearest valid port to ptr wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        p     = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            p = IW'((int'(ptr) + k) % NUM_IN);
            if (valid[p]) begin
                idx   = p;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-granular round-robin merge of NUM_IN AXI-stream ports into one registered stream
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_IN     = DEF_NUM_IN,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEST_WIDTH = DEF_DEST_WIDTH,
    parameter int USER_WIDTH = DEF_USER_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   s_data,
    input  logic [NUM_IN*DEST_WIDTH-1:0]   s_dest,
    input  logic [NUM_IN*DATA_WIDTH/8-1:0] s_keep,
    input  logic [NUM_IN*USER_WIDTH-1:0]   s_user,
    input  logic [NUM_IN-1:0]              s_last,
    input  logic [NUM_IN-1:0]              s_valid,
    output logic [NUM_IN-1:0]              s_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [DEST_WIDTH-1:0]          m_dest,
    output logic [DATA_WIDTH/8-1:0]        m_keep,
    output logic [USER_WIDTH-1:0]          m_user,
    output logic                           m_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [$clog2(NUM_IN)-1:0]      grant_idx,
    output logic                           busy
);
    localparam int IW = $clog2(NUM_IN);
    localparam int KW = DATA_WIDTH / 8;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] pick;
    logic          found;
    logic          take;

    axis_rr_picker #(.NUM_IN(NUM_IN), .IW(IW)) u_picker (
        .valid (s_valid),
        .ptr   (rr_ptr),
        .idx   (pick),
        .found (found)
    );

    assign busy    = (state == BUSY);
    assign s_ready = (busy && (!m_valid || m_ready)) ? NUM_IN'(1) << grant_idx : '0;
    assign take    = s_valid[grant_idx] && s_ready[grant_idx];

    // arbitration FSM plus output register; a beat is captured only from the locked port
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_dest    <= '0;
            m_keep    <= '0;
            m_user    <= '0;
            m_last    <= 1'b0;
        end else begin
            if (take) begin
                m_data  <= s_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                m_dest  <= s_dest[grant_idx*DEST_WIDTH +: DEST_WIDTH];
                m_keep  <= s_keep[grant_idx*KW +: KW];
                m_user  <= s_user[grant_idx*USER_WIDTH +: USER_WIDTH];
                m_last  <= s_last[grant_idx];
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (state == IDLE && found) begin
                grant_idx <= pick;
                state     <= BUSY;
            end else if (take && s_last[grant_idx]) begin
                state  <= IDLE;
                rr_ptr <= IW'(rr_next(int'(grant_idx), NUM_IN));
            end
        end
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: vector table, corner-case sequences and randomized round-robin scoreboard
module tb_axis_packet_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] s_data = '0;
    logic [N*8-1:0]  s_dest = '0;
    logic [N*KW-1:0] s_keep = '0;
    logic [N*8-1:0]  s_user = '0;
    logic [N-1:0]    s_last = '0;
    logic [N-1:0]    s_valid = '0;
    logic [N-1:0]    s_ready;
    logic [DW-1:0]   m_data;
    logic [7:0]      m_dest;
    logic [KW-1:0]   m_keep;
    logic [7:0]      m_user;
    logic            m_last;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [1:0]      grant_idx;
    logic            busy;

    always #5 clk = ~clk;

    axis_packet_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .DEST_WIDTH(8), .USER_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_dest(s_dest), .s_keep(s_keep), .s_user(s_user),
        .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_dest(m_dest), .m_keep(m_keep), .m_user(m_user),
        .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .grant_idx(grant_idx), .busy(busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [7:0]    dest;
        logic [KW-1:0] keep;
        logic [7:0]    user;
        logic          last;
    } beat_t;

    typedef struct {
        int          port;
        logic [63:0] data;
        logic [7:0]  dest;
        logic [7:0]  keep;
        logic [7:0]  user;
        logic [1:0]  eg;
    } vec_t;

    beat_t q[N][$];
    beat_t outs[$];
    beat_t exp_out[$];
    int    outc[$];
    int    gl[$];
    int    exp_g[$];
    int    hold[N];
    bit    mid[N];
    int    gap_pct = 0;
    int    rdy_pct = 100;
    int    cyc = 0;
    bit    busy_q = 0;
    int    passed = 0;
    int    total = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        for (int p = 0; p < N; p++) begin
            if (hold[p] == 0 && mid[p] && $urandom_range(99) < gap_pct) hold[p] = $urandom_range(3, 1);
            if (hold[p] > 0) begin
                s_valid[p] = 1'b0;
                hold[p]--;
            end else begin
                s_valid[p] = q[p].size() > 0;
            end
            if (q[p].size() > 0) begin
                s_data[p*DW +: DW] = q[p][0].data;
                s_dest[p*8 +: 8]   = q[p][0].dest;
                s_keep[p*KW +: KW] = q[p][0].keep;
                s_user[p*8 +: 8]   = q[p][0].user;
                s_last[p]          = q[p][0].last;
            end
        end
        m_ready = $urandom_range(99) < rdy_pct;
        #1;
    endtask

    task automatic adv();
        logic [N-1:0] xs;
        bit           oh;
        beat_t        o;
        beat_t        b;
        if (!rst) chk("ready_rule", (s_ready == 0) || (busy && s_ready == (4'b1 << grant_idx)), 1);
        xs = s_valid & s_ready;
        oh = m_valid && m_ready;
        o  = {m_data, m_dest, m_keep, m_user, m_last};
        if (busy && !busy_q) gl.push_back(int'(grant_idx));
        busy_q = busy;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            for (int p = 0; p < N; p++) begin
                if (xs[p]) begin
                    b = q[p].pop_front();
                    mid[p] = !b.last;
                end
            end
            if (oh) begin
                outs.push_back(o);
                outc.push_back(cyc);
            end
        end
    endtask

    task automatic step();
        tick();
        adv();
    endtask

    task automatic clear_logs();
        outs.delete();
        outc.delete();
        gl.delete();
        busy_q = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < N; p++) begin
            q[p].delete();
            hold[p] = 0;
            mid[p] = 0;
        end
        step();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic load_pkt(int p, int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom, $urandom};
            b.dest = 8'($urandom);
            b.keep = 8'($urandom);
            b.user = 8'($urandom);
            b.last = (i == n - 1);
            q[p].push_back(b);
        end
    endtask

    // reference: all queued packets present at once, so each arbitration picks the nearest
    // non-empty port at or after the pointer and the pointer moves past the winner
    task automatic build_exp();
        beat_t cp[N][$];
        beat_t b;
        int    ptr = 0;
        int    w;
        exp_out.delete();
        exp_g.delete();
        for (int p = 0; p < N; p++) cp[p] = q[p];
        forever begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && cp[(ptr + k) % N].size() > 0) w = (ptr + k) % N;
            if (w < 0) break;
            exp_g.push_back(w);
            do begin
                b = cp[w].pop_front();
                exp_out.push_back(b);
            end while (!b.last);
            ptr = (w + 1) % N;
        end
    endtask

    task automatic run_until(int n, int budget);
        for (int c = 0; c < budget && outs.size() < n; c++) step();
        repeat (4) step();
    endtask

    task automatic check_stream(string name);
        chk({name, "_beat_count"}, outs.size(), exp_out.size());
        for (int i = 0; i < outs.size() && i < exp_out.size(); i++) chk({name, "_beat"}, outs[i], exp_out[i]);
        chk({name, "_grant_count"}, gl.size(), exp_g.size());
        for (int i = 0; i < gl.size() && i < exp_g.size(); i++) chk({name, "_grant"}, gl[i], exp_g[i]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t  tv[5];
        beat_t b;
        beat_t d2;
        bit    hit;
        bit    loaded;
        bit    dropped;

        tv[0] = '{2, 64'hDEAD_BEEF_0123_4567, 8'h05, 8'hFF, 8'h00, 2'd2};
        tv[1] = '{0, 64'h0000_0000_0000_0000, 8'hFF, 8'h01, 8'hA5, 2'd0};
        tv[2] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 8'h0F, 8'h5A, 2'd3};
        tv[3] = '{1, 64'h1234_5678_9ABC_DEF0, 8'h7E, 8'hF0, 8'hFF, 2'd1};
        tv[4] = '{2, 64'hA5A5_5A5A_C3C3_3C3C, 8'h00, 8'h81, 8'h3C, 2'd2};

        do_reset();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_dest", m_dest, 0);

        for (int i = 0; i < 5; i++) begin
            b = '{tv[i].data, tv[i].dest, tv[i].keep, tv[i].user, 1'b1};
            q[tv[i].port].push_back(b);
            tick();
            chk("vec_arb_ready", s_ready, 0);
            adv();
            tick();
            chk("vec_ready", s_ready, 4'b1 << tv[i].port);
            chk("vec_busy", busy, 1);
            adv();
            tick();
            chk("vec_m_valid", m_valid, 1);
            chk("vec_m_data", m_data, tv[i].data);
            chk("vec_m_dest", m_dest, tv[i].dest);
            chk("vec_m_keep", m_keep, tv[i].keep);
            chk("vec_m_user", m_user, tv[i].user);
            chk("vec_m_last", m_last, 1);
            chk("vec_grant", grant_idx, tv[i].eg);
            adv();
            tick();
            chk("vec_drain_valid", m_valid, 0);
            chk("vec_drain_busy", busy, 0);
            adv();
        end

        do_reset();
        load_pkt(0, 3);
        load_pkt(2, 3);
        build_exp();
        run_until(6, 60);
        check_stream("pair");

        do_reset();
        for (int p = 0; p < N; p++) repeat (3) load_pkt(p, 1);
        build_exp();
        run_until(12, 100);
        check_stream("rr_single");
        for (int i = 1; i < outc.size(); i++) chk("rr_bubble", outc[i] - outc[i-1], 2);

        do_reset();
        load_pkt(1, 4);
        build_exp();
        d2 = q[1][1];
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            if (m_valid && m_data === d2.data) hit = 1;
            else adv();
        end
        chk("stall_reached", hit, 1);
        rdy_pct = 0;
        m_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk("stall_data", m_data, d2.data);
            chk("stall_valid", m_valid, 1);
            chk("stall_ready", s_ready, 0);
            adv();
        end
        rdy_pct = 100;
        run_until(4, 30);
        check_stream("stall");

        do_reset();
        load_pkt(3, 4);
        build_exp();
        loaded = 0;
        dropped = 0;
        for (int c = 0; c < 40 && outs.size() < 6; c++) begin
            if (!loaded && gl.size() == 1) begin
                load_pkt(0, 2);
                foreach (q[0][i]) exp_out.push_back(q[0][i]);
                exp_g.push_back(0);
                loaded = 1;
            end
            if (!dropped && q[3].size() == 2) begin
                hold[3] = 3;
                dropped = 1;
            end
            tick();
            if (dropped && q[3].size() == 2) begin
                chk("drop_grant", grant_idx, 3);
                chk("drop_busy", busy, 1);
                chk("drop_ready0", s_ready[0], 0);
            end
            adv();
        end
        repeat (4) step();
        check_stream("drop");

        do_reset();
        load_pkt(2, 1);
        run_until(1, 20);
        load_pkt(1, 5);
        for (int c = 0; c < 30 && q[1].size() > 3; c++) step();
        chk("rst_mid_reached", q[1].size(), 3);
        rst = 1'b1;
        step();
        #1;
        chk("rst_mid_m_valid", m_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_s_ready", s_ready, 0);
        chk("rst_mid_grant", grant_idx, 0);
        rst = 1'b0;
        q[1].delete();
        mid[1] = 0;
        hold[1] = 0;
        clear_logs();
        repeat (2) step();
        chk("rst_mid_quiet", outs.size(), 0);
        load_pkt(1, 2);
        load_pkt(3, 1);
        build_exp();
        run_until(3, 40);
        check_stream("restart");

        for (int r = 0; r < 3; r++) begin
            do_reset();
            gap_pct = 30;
            rdy_pct = 60;
            for (int p = 0; p < N; p++) begin
                int np;
                np = $urandom_range(4, 0);
                for (int k = 0; k < np; k++) load_pkt(p, $urandom_range(4, 1));
            end
            build_exp();
            run_until(exp_out.size(), 2000);
            check_stream("random");
            gap_pct = 0;
            rdy_pct = 100;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
